fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-stage program-counter unit with a bimodal branch predictor. It sits directly upstream of the F/D pipeline register. Each cycle it presents the fetch PC to instruction memory and hands the PC, the fetched instruction and a predicted-taken bit to that register. It accepts misprediction redirects and branch-outcome training from the execute stage.

## Interface
- `BHT_ENTRIES`, default 32: number of 2-bit counters; power of two, minimum 4.
- `RESET_PC`, default 32'd0: PC loaded on reset.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low. Clears all state while low.
- `stall` in 1: hold the PC; driven together with F/D `we` = !stall.
- `imem_addr` out 32: current PC to instruction memory (combinational from the PC register).
- `instr_in` in 32: instruction memory read data for `imem_addr`, same cycle.
- `pc_out` out 32: current PC, to the F/D register `pc_in`.
- `instruction_out` out 32: `instr_in` passed through, to the F/D register `instruction_in`.
- `branchPredictedTaken_out` out 1: prediction for the current instruction, to the F/D register `branchPredictedTaken_in`.
- `resolve_valid` in 1: execute stage resolved a conditional branch this cycle.
- `resolve_pc` in 32: PC of the resolved branch.
- `resolve_taken` in 1: actual outcome of the resolved branch.
- `mispredict` in 1: redirect request from execute.
- `redirect_pc` in 32: correct next PC when `mispredict` is high.

## Operation
- Predecode `instr_in[31:27]`:
  - conditional branch: bne = 00010, blt = 00110;
  - unconditional jump: j = 00001, jal = 00011;
  - everything else is sequential.
- Arithmetic, all modulo 2^32:
  - branch target = pc + 1 + sign-extend(`instr_in[16:0]`);
  - jump target = zero-extend(`instr_in[26:0]`);
  - sequential = pc + 1.
- BHT:
  - `BHT_ENTRIES` 2-bit saturating counters, index = PC[log2(BHT_ENTRIES)-1:0];
  - encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T;
  - predict taken = counter[1].
- `branchPredictedTaken_out` = conditional-branch opcode AND counter[1]. It is 0 for jumps and non-branches. Jumps are always redirected and are not flagged.
- Next-PC priority, highest first:
  1. reset;
  2. `mispredict` → `redirect_pc`, even when `stall` is high;
  3. `stall` → hold;
  4. predicted-taken branch → branch target;
  5. jump → jump target;
  6. otherwise pc + 1.
- Training: on `resolve_valid`, counter[resolve_pc index] increments (taken) or decrements (not taken), saturating at 11 and 00. Training is independent of `stall` and `mispredict`.

## Timing
- Reset values:
  - PC = `RESET_PC`, so `imem_addr` and `pc_out` show `RESET_PC`;
  - all counters = 01;
  - `branchPredictedTaken_out` is forced 0 while `reset` is low.
- The PC register updates on the rising edge. The new PC is visible on `imem_addr` in the same cycle it is loaded. Prediction and next-PC logic are combinational within the cycle.
- Redirect latency: `mispredict` sampled at edge N gives `pc_out` = `redirect_pc` after edge N.
- Training latency: a counter updated at edge N affects predictions from cycle N+1. A same-cycle read of the entry being written returns the pre-update value.
- Simultaneous `mispredict` and `resolve_valid` (same branch): both take effect at the same edge.
- Reset mid-operation: asynchronous clear. A pending redirect or training update is discarded.
- PC wrap: 32'hFFFFFFFF + 1 = 0, no flag.

## Configuration
- `FETCH_BHT_EN` defined: BHT instantiated and behaves as above.
- `FETCH_BHT_EN` undefined:
  - no counter storage;
  - static not-taken: `branchPredictedTaken_out` tied 0;
  - conditional branches fall through to pc + 1;
  - `resolve_valid`, `resolve_pc` and `resolve_taken` are ignored;
  - jumps and redirects are unchanged.

## Structure
- Shared package holds:
  - opcode constants (BNE, BLT, J, JAL);
  - the 2-bit counter type and its four encodings;
  - the weak-NT reset constant;
  - the immediate and target field widths (17, 27).
- Sub-module `branch_history_table`: counter array with async reset, a combinational read port and a saturating update port. It is instantiated only under `FETCH_BHT_EN`.

## Test plan
- Reset release: `RESET_PC` = 0 with nops on `instr_in` → `pc_out` steps 0, 1, 2, 3; `branchPredictedTaken_out` = 0.
- Jump: j with target 27'd100 at PC 5 → next `pc_out` = 100, prediction 0.
- Training: bne at PC 8, imm = −3, with `resolve_valid` and `resolve_taken` applied twice → counter goes 01 → 10 → 11. Next fetch of PC 8 gives prediction 1 and next PC 6. Four not-taken resolves then bring the counter to 00 and the prediction to 0.
- Stall plus redirect:
  - `stall` = 1 holds PC 20 for 3 cycles;
  - `mispredict` = 1 with `redirect_pc` = 40 while still stalled → `pc_out` = 40 after one edge.
- Reset mid-run: assert `reset` low between edges at PC 57 → `pc_out` = `RESET_PC` immediately, and all counters read 01 after release.
- Without `FETCH_BHT_EN`: repeated taken resolves of a blt → prediction stays 0 and PC stays sequential.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage constants, counter type and helpers.
// Optional BHT is enabled with the FETCH_BHT_EN macro.
package fetch_pc_unit_pkg;

  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;

  localparam int IMM_W = 17;
  localparam int TGT_W = 27;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  localparam ctr_t CTR_RESET = CTR_WNT;

  function automatic ctr_t ctr_next(
    input ctr_t c,
    input logic taken
  );
    ctr_t r;
    if (taken)
      r = (c == CTR_ST) ? CTR_ST : c + 2'd1;
    else
      r = (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_bht.sv
// Bimodal branch history table: 2-bit saturating counters,
// combinational read, one saturating update per cycle.
import fetch_pc_unit_pkg::*;

module branch_history_table #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  ctr_t ctr_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= CTR_RESET;
    end else if (upd_i) begin
      ctr_q[upd_idx_i] <=
        ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

  assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generation with predecode and optional bimodal
// prediction (FETCH_BHT_EN); otherwise static not-taken.
import fetch_pc_unit_pkg::*;

module fetch_pc_unit #(
  parameter int          BHT_ENTRIES = 32,
  parameter logic [31:0] RESET_PC    = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        branchPredictedTaken_out,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [4:0]  opc;
  logic        is_cond;
  logic        is_jump;
  logic        pred_taken;

  assign opc = instr_in[31:27];

  always_comb begin
    is_cond = 1'b0;
    is_jump = 1'b0;
    unique case (1'b1)
      (opc == OP_BNE),
      (opc == OP_BLT): is_cond = 1'b1;
      (opc == OP_J),
      (opc == OP_JAL): is_jump = 1'b1;
      default: ;
    endcase
  end

  assign br_tgt = pc_q + 32'd1
    + {{(32-IMM_W){instr_in[IMM_W-1]}},
       instr_in[IMM_W-1:0]};
  assign jmp_tgt = {{(32-TGT_W){1'b0}},
                    instr_in[TGT_W-1:0]};

`ifdef FETCH_BHT_EN
  logic [1:0] ctr;
  logic       unused_bits;

  branch_history_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (reset),
    .rd_idx_i    (pc_q[IDX_W-1:0]),
    .rd_ctr_o    (ctr),
    .upd_i       (resolve_valid),
    .upd_idx_i   (resolve_pc[IDX_W-1:0]),
    .upd_taken_i (resolve_taken)
  );

  assign pred_taken  = is_cond & ctr[1];
  assign unused_bits = ^{resolve_pc[31:IDX_W], ctr[0]};
`else
  logic unused_bits;

  assign pred_taken  = 1'b0;
  assign unused_bits = ^{resolve_valid, resolve_pc,
                         resolve_taken, is_cond};
`endif

  // Redirect beats stall so execute can always recover.
  always_comb begin
    if (mispredict)
      pc_d = redirect_pc;
    else if (stall)
      pc_d = pc_q;
    else if (pred_taken)
      pc_d = br_tgt;
    else if (is_jump)
      pc_d = jmp_tgt;
    else
      pc_d = pc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  assign imem_addr       = pc_q;
  assign pc_out          = pc_q;
  assign instruction_out = instr_in;
  assign branchPredictedTaken_out = pred_taken & reset;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; expectations follow
// the build (FETCH_BHT_EN defined or not).
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

`ifdef FETCH_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        pred;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;

  localparam logic [31:0] NOP    = 32'h0;
  localparam logic [31:0] J100   = {OP_J, 27'd100};
  localparam logic [31:0] JALMAX = {OP_JAL, 27'h7FFFFFF};
  localparam logic [31:0] BNE_M3 = {OP_BNE, 10'd0, 17'h1FFFD};
  localparam logic [31:0] BLT_P5 = {OP_BLT, 10'd0, 17'd5};

  int n_cmp = 0;
  int n_err = 0;

  fetch_pc_unit #(
    .BHT_ENTRIES (32),
    .RESET_PC    (32'd0)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .stall                    (stall),
    .imem_addr                (imem_addr),
    .instr_in                 (instr_in),
    .pc_out                   (pc_out),
    .instruction_out          (instruction_out),
    .branchPredictedTaken_out (pred),
    .resolve_valid            (resolve_valid),
    .resolve_pc               (resolve_pc),
    .resolve_taken            (resolve_taken),
    .mispredict               (mispredict),
    .redirect_pc              (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    instr_in    = NOP;
    mispredict  = 1'b1;
    redirect_pc = pc;
    step();
    mispredict  = 1'b0;
  endtask

  logic exp_nt [4];

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    mispredict    = 1'b0;
    redirect_pc   = 32'd0;
    resolve_valid = 1'b0;
    resolve_pc    = 32'd0;
    resolve_taken = 1'b0;
    instr_in      = BNE_M3;
    #1;
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_imem", imem_addr, 32'd0);
    chk("rst_pred", pred, 0);
    #2;
    reset    = 1'b1;
    instr_in = NOP;
    chk("seq0", pc_out, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq", pc_out, i);
    end
    instr_in = J100;
    chk("instr_pass", instruction_out, J100);
    chk("j_pred", pred, 0);
    step();
    chk("j_tgt", pc_out, 32'd100);
    instr_in = JALMAX;
    step();
    chk("jal_tgt", pc_out, 32'h07FFFFFF);

    // train bne at 8 taken twice while stalled
    redir(32'd8);
    chk("redir8", pc_out, 32'd8);
    instr_in      = BNE_M3;
    stall         = 1'b1;
    resolve_valid = 1'b1;
    resolve_pc    = 32'd8;
    resolve_taken = 1'b1;
    chk("bne_pred_wnt", pred, 0);
    step();
    chk("bne_pred_wt", pred, BHT);
    step();
    resolve_valid = 1'b0;
    chk("bne_pred_st", pred, BHT);
    chk("stall_hold8", pc_out, 32'd8);
    stall = 1'b0;
    step();
    chk("bne_next", pc_out, BHT ? 32'd6 : 32'd9);

    redir(32'd8);
    instr_in      = BNE_M3;
    stall         = 1'b1;
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    chk("nt_pre", pred, BHT);
    exp_nt = '{BHT, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nt_train", pred, exp_nt[i]);
    end
    resolve_taken = 1'b1;
    step();
    chk("sat_lo", pred, 0);
    resolve_valid = 1'b0;
    stall = 1'b0;
    step();
    chk("bne_nt_next", pc_out, 32'd9);

    // stall then redirect while stalled
    redir(32'd20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall20", pc_out, 32'd20);
    end
    mispredict  = 1'b1;
    redirect_pc = 32'd40;
    step();
    mispredict = 1'b0;
    stall      = 1'b0;
    chk("stall_redir", pc_out, 32'd40);

    // blt at 30, repeated taken, then saturate-high probe
    redir(32'd30);
    instr_in      = BLT_P5;
    stall         = 1'b1;
    resolve_valid = 1'b1;
    resolve_pc    = 32'd30;
    resolve_taken = 1'b1;
    chk("blt_pre", pred, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("blt_t", pred, BHT);
    end
    resolve_taken = 1'b0;
    step();
    chk("sat_hi", pred, BHT);
    resolve_taken = 1'b1;
    step();
    chk("blt_pc_hold", pc_out, 32'd30);
    resolve_valid = 1'b0;
    stall = 1'b0;
    step();
    chk("blt_next", pc_out, BHT ? 32'd36 : 32'd31);

    redir(32'hFFFFFFFF);
    chk("pre_wrap", pc_out, 32'hFFFFFFFF);
    step();
    chk("wrap", pc_out, 32'd0);

    // async reset mid-run with pending redirect/training
    redir(32'd57);
    chk("pc57", pc_out, 32'd57);
    mispredict    = 1'b1;
    redirect_pc   = 32'd99;
    resolve_valid = 1'b1;
    resolve_pc    = 32'd30;
    resolve_taken = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", pc_out, 32'd0);
    chk("async_rst_imem", imem_addr, 32'd0);
    step();
    chk("rst_hold", pc_out, 32'd0);
    mispredict    = 1'b0;
    resolve_valid = 1'b0;
    #2;
    reset = 1'b1;
    chk("rst_rel", pc_out, 32'd0);
    redir(32'd30);
    instr_in      = BLT_P5;
    stall         = 1'b1;
    chk("ctr_reset_wnt", pred, 0);
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    step();
    resolve_valid = 1'b0;
    chk("ctr_reset_inc", pred, BHT);
    stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
